// File: rtl/simd_ctrl_pkg.sv
// Shared types and default widths for the SIMD cell controller.
package simd_ctrl_pkg;

    localparam int DEF_INPUT_WIDTH  = 4;
    localparam int DEF_OPND_W       = 32;
    localparam int DEF_PROD_W       = 128;
    localparam int DEF_DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/simd_ctrl_cnt.sv
// Loadable down-counter with a terminal flag (count == 1), shared by the RUN and DRAIN phases.
module simd_ctrl_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == W'(1));

endmodule

// File: rtl/simd_ctrl.sv
// Job controller for a bit-serial SIMD cell: latch operands, clear, run 2^INPUT_WIDTH cycles, drain, hand off.
// Optional SIMD_CTRL_PERF_CNT_EN adds perf_jobs / perf_busy counters.
module simd_ctrl
    import simd_ctrl_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OPND_W       = DEF_OPND_W,
    parameter int PROD_W       = DEF_PROD_W,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_opnd,
    input  logic [OPND_W-1:0] in_wgt,
    output logic              cell_rst,
    output logic              cell_en,
    output logic [OPND_W-1:0] cell_opnd,
    output logic [OPND_W-1:0] cell_wgt,
    input  logic [PROD_W-1:0] cell_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod
`ifdef SIMD_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_jobs,
    output logic [31:0]       perf_busy
`endif
);

    localparam int CNT_W = (INPUT_WIDTH + 1 > $clog2(DRAIN_CYCLES + 1)) ?
                           INPUT_WIDTH + 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(2 ** INPUT_WIDTH);
    localparam logic [CNT_W-1:0] DRN_LEN = CNT_W'(DRAIN_CYCLES);

    state_e              state_q;
    logic [OPND_W-1:0]   opnd_q, wgt_q;
    logic [PROD_W-1:0]   prod_q;
    logic                cnt_load, cnt_dec, cnt_term;
    logic [CNT_W-1:0]    cnt_val;

    // The RUN terminal cycle reloads the same counter with the drain length.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = RUN_LEN;
            end
            RUN: begin
                if (cnt_term && DRAIN_CYCLES != 0) begin
                    cnt_load = 1'b1;
                    cnt_val  = DRN_LEN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN:   cnt_dec = 1'b1;
            default: ;
        endcase
    end

    simd_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .term_o     (cnt_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            wgt_q   <= '0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    opnd_q  <= in_opnd;
                    wgt_q   <= in_wgt;
                    state_q <= LOAD;
                end
                LOAD: state_q <= RUN;
                RUN: if (cnt_term) begin
                    if (DRAIN_CYCLES == 0) begin
                        prod_q  <= cell_prod;
                        state_q <= DONE;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (cnt_term) begin
                    prod_q  <= cell_prod;
                    state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so the outputs hold their reset values before the first edge as well.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign cell_en   = (state_q == RUN)  && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign cell_rst  = rst || (state_q == LOAD);
    assign cell_opnd = opnd_q;
    assign cell_wgt  = wgt_q;
    assign out_prod  = prod_q;

`ifdef SIMD_CTRL_PERF_CNT_EN
    logic [31:0] jobs_q, busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_q <= '0;
            busy_q <= '0;
        end else begin
            if (state_q == DONE && out_ready) jobs_q <= jobs_q + 32'd1;
            if (state_q != IDLE)              busy_q <= busy_q + 32'd1;
        end
    end

    assign perf_jobs = jobs_q;
    assign perf_busy = busy_q;
`endif

endmodule

// File: tb/tb_simd_ctrl.sv
// Directed bench for simd_ctrl: cycle-exact latency, stall, ignored in_valid, mid-run reset.
module tb_simd_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_ready;
    logic [31:0]  in_opnd, in_wgt, cell_opnd, cell_wgt;
    logic         cell_rst, cell_en, out_valid;
    logic [127:0] cell_prod, out_prod;
    logic [31:0]  cyc = '0;
    int           n_vec = 0, n_err = 0;
`ifdef SIMD_CTRL_PERF_CNT_EN
    logic [31:0]  perf_jobs, perf_busy;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Cell product is a known function of the cycle number, so the capture cycle is observable.
    function automatic logic [127:0] prod_at(input logic [31:0] c);
        return {c, ~c, c ^ 32'h5A5A5A5A, 32'hC0DE0000 + c};
    endfunction
    assign cell_prod = prod_at(cyc);

    simd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opnd   (in_opnd),
        .in_wgt    (in_wgt),
        .cell_rst  (cell_rst),
        .cell_en   (cell_en),
        .cell_opnd (cell_opnd),
        .cell_wgt  (cell_wgt),
        .cell_prod (cell_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
`ifdef SIMD_CTRL_PERF_CNT_EN
        ,
        .perf_jobs (perf_jobs),
        .perf_busy (perf_busy)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the handshake.
    task automatic do_job(input logic [31:0] op, input logic [31:0] wt, input int stall,
                          input bit keep_valid);
        logic [31:0] k;
        in_valid  = 1'b1;
        in_opnd   = op;
        in_wgt    = wt;
        out_ready = 1'b0;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk("acc_rdy", in_ready, 1'b1);
        k = cyc;
        @(negedge clk);
        if (keep_valid) begin
            in_opnd = ~op;
            in_wgt  = ~wt;
        end else begin
            in_valid = 1'b0;
        end
        chk("ld_rst", cell_rst, 1'b1);
        chk("ld_en", cell_en, 1'b0);
        chk("ld_opnd", cell_opnd, op);
        chk("ld_wgt", cell_wgt, wt);
        for (int j = 2; j <= 17; j++) begin
            @(negedge clk);
            chk("run_en", cell_en, 1'b1);
            chk("run_rdy", in_ready, 1'b0);
            chk("run_opnd", cell_opnd, op);
            if (keep_valid) in_opnd = $urandom;
        end
        for (int j = 18; j <= 19; j++) begin
            @(negedge clk);
            chk("drn_en", cell_en, 1'b0);
            chk("drn_ov", out_valid, 1'b0);
        end
        @(negedge clk);
        chk("done_cyc", cyc - k, 32'd20);
        chk("done_ov", out_valid, 1'b1);
        chk("done_prod", out_prod, prod_at(k + 32'd19));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stl_ov", out_valid, 1'b1);
            chk("stl_prod", out_prod, prod_at(k + 32'd19));
            chk("stl_en", cell_en, 1'b0);
            chk("stl_wgt", cell_wgt, wt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_ov", out_valid, 1'b0);
        chk("hs_rdy", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] k;
        bit          seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_opnd = '0; in_wgt = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_en", cell_en, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_crst", cell_rst, 1'b1);
        chk("rst_prod", out_prod, 128'd0);
        chk("rst_opnd", cell_opnd, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_rdy", in_ready, 1'b1);
        chk("idle_crst", cell_rst, 1'b0);
        @(negedge clk);

        // Three back-to-back jobs with immediate out_ready.
        do_job(32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
        do_job(32'hFFFFFFFF, 32'h00000000, 0, 1'b0);
        do_job(32'h00000001, 32'h80000000, 0, 1'b0);
`ifdef SIMD_CTRL_PERF_CNT_EN
        chk("perf_jobs", perf_jobs, 32'd3);
        chk("perf_busy", perf_busy, 32'd60);
`endif

        // Long consumer stall, then in_valid held through a job followed by a second job.
        do_job(32'hA5A5A5A5, 32'h5A5A5A5A, 50, 1'b0);
        do_job(32'hDEADBEEF, 32'hCAFEF00D, 3, 1'b1);
        do_job(32'h0F0F0F0F, 32'hF0F0F0F0, 0, 1'b0);

        // Reset in the 9th RUN cycle aborts the job.
        in_valid = 1'b1; in_opnd = 32'h11112222; in_wgt = 32'h33334444;
        k = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("ab_en_pre", cell_en, 1'b1);
        chk("ab_cyc", cyc - k, 32'd10);
        rst = 1'b1;
        #1;
        chk("ab_en", cell_en, 1'b0);
        chk("ab_crst", cell_rst, 1'b1);
        chk("ab_rdy", in_ready, 1'b0);
        chk("ab_ov", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ab_idle", in_ready, 1'b1);
        chk("ab_opnd", cell_opnd, 32'd0);
        chk("ab_prod", out_prod, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid || cell_en) seen = 1'b1;
        end
        chk("ab_quiet", seen, 1'b0);
        do_job(32'h76543210, 32'h01234567, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simd_ctrl.md
SIMD_CTRL -- requirements
Module: simd_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 4: input operand bit width; run length is 2^INPUT_WIDTH cycles.
REQ-002 SHALL have parameter OPND_W, default 32: packed width of the input_bin and weight_bin operand buses.
REQ-003 SHALL have parameter PROD_W, default 128: packed width of the SIMD cell product vector.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 2: cell pipeline flush cycles after the last enabled cycle.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  operand job offered.
REQ-008 in_ready  out  1  controller accepts the job.
REQ-009 in_opnd  in  OPND_W  input_bin values for the job.
REQ-010 in_wgt  in  OPND_W  weight_bin values for the job.
REQ-011 cell_rst  out  1  active-high clear of the SIMD cell counters, accumulators and product registers.
REQ-012 cell_en  out  1  SIMD cell enable.
REQ-013 cell_opnd / cell_wgt  out  OPND_W each  latched operands driven to the cell.
REQ-014 cell_prod  in  PROD_W  SIMD cell product_reg vector.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_prod  out  PROD_W  captured result.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready, latch in_opnd/in_wgt into cell_opnd/cell_wgt and go to LOAD.
REQ-020 LOAD: one cycle; cell_rst=1, cell_en=0; load run counter with 2^INPUT_WIDTH; go to RUN.
REQ-021 RUN: cell_en=1 for exactly 2^INPUT_WIDTH consecutive cycles; counter width INPUT_WIDTH+1, decrements each cycle; when counter reaches 1, go to DRAIN.
REQ-022 DRAIN: cell_en=0 for DRAIN_CYCLES cycles; on the last DRAIN cycle, capture cell_prod into out_prod; go to DONE.
REQ-023 DONE: out_valid=1; out_prod is held stable; on out_valid&out_ready go to IDLE.
REQ-024 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored and the latched operands are unchanged.
REQ-025 cell_opnd/cell_wgt SHALL be constant from LOAD through DONE.
REQ-026 Latency: with the accept edge at cycle k, out_valid SHALL first be high in cycle k+2+2^INPUT_WIDTH+DRAIN_CYCLES.
REQ-027 out_ready held low SHALL keep the FSM in DONE indefinitely with no change to any output.
REQ-028 DRAIN_CYCLES=0 SHALL capture cell_prod at the RUN→DONE transition (DRAIN skipped).

Reset
REQ-029 rst SHALL force state IDLE and clear the run counter, cell_opnd, cell_wgt and out_prod to 0.
REQ-030 During rst: in_ready=0, cell_en=0, out_valid=0 and cell_rst=1.
REQ-031 rst asserted mid-RUN or mid-DRAIN SHALL abort the job with no result; after release, the first job behaves as in REQ-026.

Configuration
REQ-032 SIMD_CTRL_PERF_CNT_EN defined: adds output perf_jobs (32 bits, count of completed out handshakes) and perf_busy (32 bits, count of cycles not in IDLE); both clear on rst and wrap at 2^32.
REQ-033 SIMD_CTRL_PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-034 Package simd_ctrl_pkg SHALL hold the state enum type and the default width constants (INPUT_WIDTH, OPND_W, PROD_W, DRAIN_CYCLES).
REQ-035 The run/drain count SHALL live in one sub-module, simd_ctrl_cnt: a loadable down-counter with a terminal flag, instanced once and shared by RUN and DRAIN.

Verification
REQ-036 INPUT_WIDTH=4, DRAIN_CYCLES=2, accept at cycle 0 → cell_rst=1 in cycle 1; cell_en=1 in cycles 2–17; out_valid rises in cycle 20 with out_prod=cell_prod sampled in cycle 19.
REQ-037 in_valid held high through RUN with changing in_opnd → in_ready=0 and cell_opnd unchanged; second job accepted only after the DONE handshake.
REQ-038 out_ready=0 for 50 cycles in DONE → out_valid stays 1, out_prod constant, cell_en=0; out_ready=1 → IDLE on the next cycle.
REQ-039 rst pulsed at cycle 9 of RUN → next cycle IDLE, cell_en=0, cell_rst=1 during rst, out_valid never asserted; the following job has nominal 20-cycle latency.
REQ-040 SIMD_CTRL_PERF_CNT_EN, 3 back-to-back jobs with immediate out_ready → perf_jobs=3 and perf_busy=3×20=60.
